// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_pkg;

    localparam int N_REQ_DEF = 8;
    localparam int ID_W_DEF  = $clog2(N_REQ_DEF);
    localparam int MAX_VEC_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Binary index of the set bit; a legal one-hot (or zero) input is assumed.
    function automatic int unsigned onehot_to_idx(input logic [MAX_VEC_W-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_VEC_W; i++) begin
            if (vec[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first request at or after (last+1), wrapping.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] winner_onehot,
    output logic [ID_W-1:0]  winner_id,
    output logic             any_req
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        winner_onehot = '0;
        found         = 1'b0;
        idx           = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(last) + 1 + k) % N_REQ);
            if (!found && req[idx]) begin
                winner_onehot[idx] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    assign winner_id = ID_W'(onehot_to_idx(MAX_VEC_W'(winner_onehot)));
    assign any_req   = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant for the byte-lane mux select.
// Optional BUS_ARB_LOCK_EN adds a lock input that suppresses tenure expiry.
//
// state | meaning
// IDLE  | no owner; grant all-zero, waiting for any request
// GRANT | one owner holds the bus; hold_cnt tracks its tenure
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = 4,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef BUS_ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id
);

    localparam int HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    arb_state_t       state, state_d;
    logic [N_REQ-1:0] grant_d;
    logic [ID_W-1:0]  grant_id_d;
    logic [HC_W-1:0]  hold_cnt, hold_cnt_d;
    logic [ID_W-1:0]  last, last_d;
    logic [ID_W-1:0]  pick_last;
    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  win_id;
    logic             any_req;
    logic             lock_hold;
    logic             at_limit;
    logic             release_now;

`ifdef BUS_ARB_LOCK_EN
    assign lock_hold = lock && req[grant_id];
`else
    assign lock_hold = 1'b0;
`endif

    // On release the search restarts just past the outgoing owner in the same cycle.
    assign pick_last   = (state == GRANT) ? grant_id : last;
    assign at_limit    = (MAX_HOLD != 0) && (hold_cnt == HC_W'(HOLD_LAST));
    assign release_now = !req[grant_id] || (at_limit && !lock_hold);

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req          (req),
        .last         (pick_last),
        .winner_onehot(win_onehot),
        .winner_id    (win_id),
        .any_req      (any_req)
    );

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        grant_id_d = grant_id;
        hold_cnt_d = hold_cnt;
        last_d     = last;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_d    = win_onehot;
                    grant_id_d = win_id;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_d     = grant_id;
                    hold_cnt_d = '0;
                    if (any_req) begin
                        grant_d    = win_onehot;
                        grant_id_d = win_id;
                    end else begin
                        grant_d    = '0;
                        grant_id_d = '0;
                        state_d    = IDLE;
                    end
                end else if (!at_limit) begin
                    hold_cnt_d = hold_cnt + HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            last     <= ID_W'(N_REQ - 1);
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            grant_id <= grant_id_d;
            hold_cnt <= hold_cnt_d;
            last     <= last_d;
        end
    end

    assign grant_valid = |grant;

endmodule
